// File: rtl/axis_check_module_if.sv
// Receive-side AXI4-Stream bundle (no tready) carrying MAC RX beats into
// the traffic checker.
interface axis_check_module_if;
  logic         tvalid;
  logic [255:0] tdata;
  logic [31:0]  tkeep;
  logic         tlast;
  logic         tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser);
  modport slave  (input  tvalid, tdata, tkeep, tlast, tuser);
endinterface

// File: rtl/axis_check_module.sv
// Per-port 40G RX traffic checker: validates generator-format frames
// (sequence, length field, byte pattern, tkeep shape, FCS) and keeps
// saturating statistics counters.
module axis_check_module #(
  parameter int P_MIN_LENGTH = 64,
  parameter int P_MAX_LENGTH = 9600,
  parameter int P_CNT_WIDTH  = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_stat_rx_status,
  axis_check_module_if.slave     s_axis_rx,
  output logic [P_CNT_WIDTH-1:0] o_frame_cnt,
  output logic [P_CNT_WIDTH-1:0] o_good_cnt,
  output logic [P_CNT_WIDTH-1:0] o_err_cnt,
  output logic [P_CNT_WIDTH-1:0] o_fcs_err_cnt,
  output logic [P_CNT_WIDTH-1:0] o_seq_err_cnt,
  output logic [P_CNT_WIDTH-1:0] o_byte_cnt,
  output logic                   o_err_pulse,
  output logic [2:0]             o_last_err_code
);

  localparam logic [15:0] MIN_LEN = 16'(P_MIN_LENGTH);
  localparam logic [15:0] MAX_LEN = 16'(P_MAX_LENGTH);

  localparam logic [2:0] CODE_NONE = 3'd0;
  localparam logic [2:0] CODE_PAT  = 3'd1;
  localparam logic [2:0] CODE_LEN  = 3'd2;
  localparam logic [2:0] CODE_SIZE = 3'd3;
  localparam logic [2:0] CODE_KEEP = 3'd4;
  localparam logic [2:0] CODE_FCS  = 3'd5;

  typedef enum logic [0:0] {S_IDLE, S_BODY} state_t;

  state_t state, state_nxt;

  // 16-bit frame byte accumulator add that sticks at all-ones
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [5:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {11'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Statistics counter add that sticks at all-ones
  function automatic logic [P_CNT_WIDTH-1:0] sat_add_cnt(input logic [P_CNT_WIDTH-1:0] a,
                                                         input logic [15:0] b);
    logic [P_CNT_WIDTH:0] s;
    logic [P_CNT_WIDTH:0] bx;
    bx = '0;
    bx[15:0] = b;
    s = {1'b0, a} + bx;
    return s[P_CNT_WIDTH] ? {P_CNT_WIDTH{1'b1}} : s[P_CNT_WIDTH-1:0];
  endfunction

  function automatic logic [5:0] popcnt32(input logic [31:0] k);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, k[i]};
    return c;
  endfunction

  // Body beats must be full; the last beat must be a non-empty run from lane 0
  function automatic logic keep_bad(input logic [31:0] k, input logic last);
    if (last) return (k == 32'd0) || ((k & (k + 32'd1)) != 32'd0);
    return k != 32'hFFFFFFFF;
  endfunction

  // Byte k of the frame must equal k[7:0]; header lanes of beat 0 are exempt.
  // Only beat[2:0] matters because the pattern repeats every 256 bytes.
  function automatic logic pattern_bad(input logic [255:0] d, input logic [31:0] k,
                                       input logic [2:0] beat, input logic first);
    logic       bad;
    logic [7:0] exp_b;
    bad = 1'b0;
    for (int j = 0; j < 32; j++) begin
      exp_b = {beat, 5'd0} + 8'(j);
      if (k[j] && !(first && j < 6) && (d[8*j +: 8] != exp_b)) bad = 1'b1;
    end
    return bad;
  endfunction

  // Frame accumulators (data path, overwritten by every first beat)
  logic [15:0] acc_bytes;
  logic        acc_keep_err;
  logic        acc_pat_err;
  logic [31:0] seq_hold;
  logic [15:0] len_hold;
  logic [2:0]  beat_idx;

  // Sequence tracking
  logic        seq_sync;
  logic [31:0] seq_exp;

  // Stage 0 combinational view of the incoming beat
  logic        beat_p0, first_p0, fin_p0;
  logic [2:0]  beat_lo_p0;
  logic [15:0] bytes_p0, len_p0;
  logic [31:0] seq_p0;
  logic        keep_err_p0, pat_err_p0, size_err_p0, len_err_p0, fcs_err_p0;
  logic        seq_err_p0, bad_p0;
  logic [2:0]  code_p0;

  assign beat_p0  = s_axis_rx.tvalid && i_stat_rx_status;
  assign first_p0 = (state == S_IDLE);
  assign fin_p0   = beat_p0 && s_axis_rx.tlast;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: link loss always aborts back to idle
  always_comb begin
    state_nxt = state;
    if (!i_stat_rx_status)  state_nxt = S_IDLE;
    else if (beat_p0)       state_nxt = s_axis_rx.tlast ? S_IDLE : S_BODY;
  end

  // Merge the current beat into the running frame flags and verdict
  always_comb begin
    beat_lo_p0  = first_p0 ? 3'd0 : beat_idx;
    seq_p0      = first_p0 ? s_axis_rx.tdata[31:0]  : seq_hold;
    len_p0      = first_p0 ? s_axis_rx.tdata[47:32] : len_hold;
    bytes_p0    = sat_add16(first_p0 ? 16'd0 : acc_bytes,
                            s_axis_rx.tlast ? popcnt32(s_axis_rx.tkeep) : 6'd32);
    keep_err_p0 = (!first_p0 && acc_keep_err) || keep_bad(s_axis_rx.tkeep, s_axis_rx.tlast);
    pat_err_p0  = (!first_p0 && acc_pat_err) ||
                  pattern_bad(s_axis_rx.tdata, s_axis_rx.tkeep, beat_lo_p0, first_p0);
    size_err_p0 = (bytes_p0 < MIN_LEN) || (bytes_p0 > MAX_LEN);
    len_err_p0  = (len_p0 != bytes_p0);
    fcs_err_p0  = s_axis_rx.tuser;
    seq_err_p0  = fin_p0 && !fcs_err_p0 && seq_sync && (seq_p0 != seq_exp);
    code_p0     = CODE_NONE;
    if (fcs_err_p0)       code_p0 = CODE_FCS;
    else if (keep_err_p0) code_p0 = CODE_KEEP;
    else if (size_err_p0) code_p0 = CODE_SIZE;
    else if (len_err_p0)  code_p0 = CODE_LEN;
    else if (pat_err_p0)  code_p0 = CODE_PAT;
    bad_p0      = (code_p0 != CODE_NONE);
  end

  // Carry frame accumulators across beats
  always_ff @(posedge i_clk) begin
    if (beat_p0) begin
      acc_bytes    <= bytes_p0;
      acc_keep_err <= keep_err_p0;
      acc_pat_err  <= pat_err_p0;
      seq_hold     <= seq_p0;
      len_hold     <= len_p0;
      beat_idx     <= beat_lo_p0 + 3'd1;
    end
  end

  // Sequence sync: cleared on reset or link loss, FCS-bad frames leave it alone
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_stat_rx_status) begin
      seq_sync <= 1'b0;
    end else if (fin_p0 && !fcs_err_p0) begin
      seq_sync <= 1'b1;
      seq_exp  <= seq_p0 + 32'd1;
    end
  end

  // Stage 1: registered verdict, statistics and sticky error code
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_frame_cnt     <= '0;
      o_good_cnt      <= '0;
      o_err_cnt       <= '0;
      o_fcs_err_cnt   <= '0;
      o_seq_err_cnt   <= '0;
      o_byte_cnt      <= '0;
      o_err_pulse     <= 1'b0;
      o_last_err_code <= CODE_NONE;
    end else begin
      o_err_pulse <= fin_p0 && bad_p0;
      if (fin_p0) begin
        o_frame_cnt <= sat_add_cnt(o_frame_cnt, 16'd1);
        if (bad_p0) begin
          o_err_cnt       <= sat_add_cnt(o_err_cnt, 16'd1);
          o_last_err_code <= code_p0;
        end else begin
          o_good_cnt <= sat_add_cnt(o_good_cnt, 16'd1);
          o_byte_cnt <= sat_add_cnt(o_byte_cnt, bytes_p0);
        end
        if (fcs_err_p0) o_fcs_err_cnt <= sat_add_cnt(o_fcs_err_cnt, 16'd1);
        if (seq_err_p0) o_seq_err_cnt <= sat_add_cnt(o_seq_err_cnt, 16'd1);
      end
    end
  end

endmodule
